// File: rtl/reset_pkg.sv
// Shared types for the reset sequencer: cause codes, FSM states, output bundle.
package reset_pkg;

  typedef enum logic [1:0] {
    RST_CAUSE_NONE = 2'b00,
    RST_CAUSE_POR  = 2'b01,
    RST_CAUSE_SW   = 2'b10,
    RST_CAUSE_WDT  = 2'b11
  } rst_cause_e;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'b00,
    ST_REL_PERIPH = 2'b01,
    ST_RUN        = 2'b10
  } rst_state_e;

  // Registered reset outputs kept together so they share one flop bank.
  typedef struct packed {
    logic periph_rst_n;
    logic core_rst_n;
    logic rst_done;
  } rst_out_t;

  // Watchdog outranks software when both requests land in the same cycle.
  function automatic rst_cause_e req_cause(input logic wdt);
    return wdt ? RST_CAUSE_WDT : RST_CAUSE_SW;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_n
);

  logic [STAGES-1:0] sync_pipe;

  // Clear the whole chain as soon as reset_n drops; shift ones in after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[STAGES-2:0], 1'b1};
  end

  assign sync_n = sync_pipe[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: synchronises reset_n, stretches it, releases peripheral
// then core resets, services soft/watchdog restarts, keeps a sticky cause.
module reset_seq_ctrl
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int SEQ_GAP     = 4,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_reset_req,
  input  logic       wdt_expire,
  input  logic       cause_clr,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [1:0] reset_cause
);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic       sync_n;
  logic       req;
  rst_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rst_out_t   out_q, out_d;
  rst_cause_e cause_q, cause_d;

  reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_n  (sync_n)
  );

  assign req = sw_reset_req | wdt_expire;

  // State, counter, outputs and cause; the synchronised reset clears them all.
  always_ff @(posedge clk or negedge sync_n) begin
    if (!sync_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      out_q   <= '0;
      cause_q <= RST_CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cause_q <= cause_d;
    end
  end

  // Next-state, counter and output decode; requests only act in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cause_d = cause_q;
    if (cause_clr) cause_d = RST_CAUSE_NONE;
    case (state_q)
      ST_HOLD: begin
        out_d = '0;
        if (cnt_q == STRETCH_LAST) begin
          state_d            = ST_REL_PERIPH;
          cnt_d              = '0;
          out_d.periph_rst_n = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REL_PERIPH: begin
        if (cnt_q == GAP_LAST) begin
          state_d          = ST_RUN;
          cnt_d            = '0;
          out_d.core_rst_n = 1'b1;
          out_d.rst_done   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          out_d   = '0;
          cause_d = req_cause(wdt_expire);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        out_d   = '0;
      end
    endcase
  end

  assign periph_rst_n = out_q.periph_rst_n;
  assign core_rst_n   = out_q.core_rst_n;
  assign rst_done     = out_q.rst_done;
  assign reset_cause  = cause_q;

endmodule
